// File: rtl/cc_bus_ctrl.sv
// cc_bus_ctrl: MSI coherence bus controller between two data caches and one single-ported RAM.
// Optional CC_ARB_RR_EN selects round-robin arbitration; otherwise core 0 wins ties.
module cc_bus_ctrl #(
   parameter int NCORE    = 2,
   parameter int BLKWORDS = 2
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic [NCORE-1:0]       dREN,
   input  logic [NCORE-1:0]       dWEN,
   input  logic [NCORE-1:0][31:0] daddr,
   input  logic [NCORE-1:0][31:0] dstore,
   input  logic [NCORE-1:0]       cctrans,
   input  logic [NCORE-1:0]       ccwrite,
   output logic [NCORE-1:0]       dwait,
   output logic [NCORE-1:0][31:0] dload,
   output logic [NCORE-1:0]       ccwait,
   output logic [NCORE-1:0]       ccinv,
   output logic [NCORE-1:0][31:0] ccsnoopaddr,
   output logic                   ramREN,
   output logic                   ramWEN,
   output logic [31:0]            ramaddr,
   output logic [31:0]            ramstore,
   input  logic [31:0]            ramload,
   input  logic [1:0]             ramstate
);

   localparam int            CW        = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
   localparam logic [CW-1:0] LAST_WORD = CW'(BLKWORDS - 1);
   localparam logic [1:0]    RAM_ACCESS = 2'd2;

   typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, RAMRD, UPG} state_t;

   state_t        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic [CW-1:0] wcnt_q, wcnt_d;
`ifdef CC_ARB_RR_EN
   logic          ptr_q, ptr_d;
`endif

   logic       g, o, arb_g, done, word_step, xfer_end;
   logic [1:0] req;

   assign g    = gnt_q;
   assign o    = ~gnt_q;
   assign done = (ramstate == RAM_ACCESS);
   assign req  = cctrans | dWEN;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         wcnt_q  <= '0;
`ifdef CC_ARB_RR_EN
         ptr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         wcnt_q  <= wcnt_d;
`ifdef CC_ARB_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   // Tie-break: pointer (round-robin) or core 0 (fixed); a lone requester always wins.
   always_comb begin
`ifdef CC_ARB_RR_EN
      if (&req) arb_g = ptr_q;
      else      arb_g = ~req[0];
`else
      arb_g = ~req[0];
`endif
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      wcnt_d      = wcnt_q;
`ifdef CC_ARB_RR_EN
      ptr_d       = ptr_q;
`endif
      word_step   = 1'b0;
      xfer_end    = 1'b0;
      dwait       = '1;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d   = arb_g;
               state_d = (dWEN[arb_g] & ~cctrans[arb_g]) ? WB : SNOOP;
            end
         end
         WB: begin
            ramWEN    = 1'b1;
            ramaddr   = daddr[g];
            ramstore  = dstore[g];
            dwait[g]  = ~done;
            word_step = 1'b1;
            if (!dWEN[g]) xfer_end = 1'b1;
         end
         SNOOP: begin
            ccwait[o]      = 1'b1;
            ccsnoopaddr[o] = daddr[g];
            ccinv[o]       = ccwrite[g];
            if (ccwrite[o])   state_d = C2C;
            else if (dREN[g]) state_d = RAMRD;
            else              state_d = UPG;
         end
         // Modified line in the other cache: it feeds the requester and RAM in the same beat.
         C2C: begin
            ccwait[o]      = 1'b1;
            ccsnoopaddr[o] = daddr[g];
            ramWEN         = 1'b1;
            ramaddr        = daddr[o];
            ramstore       = dstore[o];
            dload[g]       = dstore[o];
            dwait[g]       = ~done;
            dwait[o]       = ~done;
            word_step      = 1'b1;
         end
         RAMRD: begin
            ccwait[o]      = 1'b1;
            ccsnoopaddr[o] = daddr[g];
            ramREN         = 1'b1;
            ramaddr        = daddr[g];
            dload[g]       = ramload;
            dwait[g]       = ~done;
            word_step      = 1'b1;
         end
         UPG: begin
            ccwait[o]      = 1'b1;
            ccsnoopaddr[o] = daddr[g];
            xfer_end       = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (word_step && done) begin
         if (wcnt_q == LAST_WORD) xfer_end = 1'b1;
         else                     wcnt_d   = wcnt_q + CW'(1);
      end

      if (xfer_end) begin
         state_d = IDLE;
         wcnt_d  = '0;
`ifdef CC_ARB_RR_EN
         ptr_d   = o;
`endif
      end
   end

endmodule

// File: tb/tb_cc_bus_ctrl.sv
// Directed bench for cc_bus_ctrl: eviction, read miss, cache-to-cache, upgrade, tie arbitration and reset.
module tb_cc_bus_ctrl;

   logic             CLK = 1'b0;
   logic             nRST;
   logic [1:0]       dREN, dWEN, cctrans, ccwrite;
   logic [1:0][31:0] daddr, dstore;
   logic [1:0]       dwait, ccwait, ccinv;
   logic [1:0][31:0] dload, ccsnoopaddr;
   logic             ramREN, ramWEN;
   logic [31:0]      ramaddr, ramstore, ramload;
   logic [1:0]       ramstate;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

   always #5 CLK = ~CLK;

   cc_bus_ctrl #(.NCORE(2), .BLKWORDS(2)) dut (
      .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload), .ccwait(ccwait),
      .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
      .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
   );

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic clear_inputs();
      dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
      daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      clear_inputs();
      #2;
      n_chk++; if (dwait !== 2'b11) $display("FAIL rst_dwait got=%b exp=11", dwait); else n_pass++;
      n_chk++; if (ccwait !== 2'b00 || ccinv !== 2'b00) $display("FAIL rst_cc got=%b/%b exp=00/00", ccwait, ccinv); else n_pass++;
      n_chk++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) $display("FAIL rst_ram got=%b%b exp=00", ramREN, ramWEN); else n_pass++;
      n_chk++; if (ramaddr !== 32'h0 || ramstore !== 32'h0 || dload !== 64'h0 || ccsnoopaddr !== 64'h0)
         $display("FAIL rst_data got=%h/%h/%h/%h exp=0", ramaddr, ramstore, dload, ccsnoopaddr); else n_pass++;
      @(negedge CLK); nRST = 1'b1;
   endtask

   task automatic test_evict();
      @(negedge CLK); dWEN = 2'b01; daddr[0] = 32'h100; dstore[0] = 32'hAAAA; ramstate = FREE; #1;
      n_chk++; if (dwait !== 2'b11 || ramWEN !== 1'b0) $display("FAIL ev_idle got=%b/%b exp=11/0", dwait, ramWEN); else n_pass++;
      @(negedge CLK); ramstate = BUSY; #1;
      n_chk++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'hAAAA)
         $display("FAIL ev_w0 got=%b%b %h %h exp=01 100 aaaa", ramREN, ramWEN, ramaddr, ramstore); else n_pass++;
      n_chk++; if (dwait !== 2'b11) $display("FAIL ev_busy got=%b exp=11", dwait); else n_pass++;
      @(negedge CLK); ramstate = BUSY; #1;
      n_chk++; if (dwait !== 2'b11) $display("FAIL ev_busy2 got=%b exp=11", dwait); else n_pass++;
      @(negedge CLK); ramstate = ACCESS; #1;
      n_chk++; if (dwait !== 2'b10 || ramaddr !== 32'h100) $display("FAIL ev_done0 got=%b %h exp=10 100", dwait, ramaddr); else n_pass++;
      @(negedge CLK); daddr[0] = 32'h104; dstore[0] = 32'hBBBB; ramstate = ERROR; #1;
      n_chk++; if (dwait !== 2'b11 || ramaddr !== 32'h104 || ramstore !== 32'hBBBB)
         $display("FAIL ev_err got=%b %h %h exp=11 104 bbbb", dwait, ramaddr, ramstore); else n_pass++;
      @(negedge CLK); ramstate = ACCESS; #1;
      n_chk++; if (dwait !== 2'b10 || ramWEN !== 1'b1) $display("FAIL ev_done1 got=%b %b exp=10 1", dwait, ramWEN); else n_pass++;
      @(negedge CLK); dWEN = 2'b00; ramstate = FREE; #1;
      n_chk++; if (ramWEN !== 1'b0 || dwait !== 2'b11 || ccwait !== 2'b00)
         $display("FAIL ev_end got=%b %b %b exp=0 11 00", ramWEN, dwait, ccwait); else n_pass++;
   endtask

   task automatic test_read_miss();
      @(negedge CLK); cctrans = 2'b10; dREN = 2'b10; daddr[1] = 32'h200; ramstate = FREE; #1;
      @(negedge CLK); #1;
      n_chk++; if (ccwait !== 2'b01 || ccsnoopaddr[0] !== 32'h200 || ccinv !== 2'b00)
         $display("FAIL rd_snoop got=%b %h %b exp=01 200 00", ccwait, ccsnoopaddr[0], ccinv); else n_pass++;
      n_chk++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) $display("FAIL rd_snoop_ram got=%b%b exp=00", ramREN, ramWEN); else n_pass++;
      @(negedge CLK); ramstate = ACCESS; ramload = 32'hCAFE0000; #1;
      n_chk++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h200)
         $display("FAIL rd_w0_ram got=%b%b %h exp=10 200", ramREN, ramWEN, ramaddr); else n_pass++;
      n_chk++; if (dload[1] !== 32'hCAFE0000 || dload[0] !== 32'h0 || dwait !== 2'b01 || ccwait !== 2'b01)
         $display("FAIL rd_w0 got=%h %h %b %b exp=cafe0000 0 01 01", dload[1], dload[0], dwait, ccwait); else n_pass++;
      @(negedge CLK); daddr[1] = 32'h204; ramload = 32'hCAFE0004; ramstate = BUSY; #1;
      n_chk++; if (dwait !== 2'b11 || ramaddr !== 32'h204) $display("FAIL rd_busy got=%b %h exp=11 204", dwait, ramaddr); else n_pass++;
      @(negedge CLK); ramstate = ACCESS; #1;
      n_chk++; if (dload[1] !== 32'hCAFE0004 || dwait !== 2'b01) $display("FAIL rd_w1 got=%h %b exp=cafe0004 01", dload[1], dwait); else n_pass++;
      @(negedge CLK); cctrans = 2'b00; dREN = 2'b00; ramstate = FREE; #1;
      n_chk++; if (ccwait !== 2'b00 || ramREN !== 1'b0) $display("FAIL rd_end got=%b %b exp=00 0", ccwait, ramREN); else n_pass++;
   endtask

   task automatic test_c2c();
      @(negedge CLK); cctrans = 2'b01; ccwrite = 2'b11; dREN = 2'b01; daddr[0] = 32'h300; #1;
      @(negedge CLK); daddr[1] = 32'h300; dstore[1] = 32'h1234; #1;
      n_chk++; if (ccwait !== 2'b10 || ccinv !== 2'b10 || ccsnoopaddr[1] !== 32'h300)
         $display("FAIL c2c_snoop got=%b %b %h exp=10 10 300", ccwait, ccinv, ccsnoopaddr[1]); else n_pass++;
      @(negedge CLK); ramstate = ACCESS; #1;
      n_chk++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h300 || ramstore !== 32'h1234)
         $display("FAIL c2c_w0_ram got=%b%b %h %h exp=01 300 1234", ramREN, ramWEN, ramaddr, ramstore); else n_pass++;
      n_chk++; if (dload[0] !== 32'h1234 || dwait !== 2'b00 || ccwait !== 2'b10)
         $display("FAIL c2c_w0 got=%h %b %b exp=1234 00 10", dload[0], dwait, ccwait); else n_pass++;
      @(negedge CLK); daddr[0] = 32'h304; daddr[1] = 32'h304; dstore[1] = 32'h5678; #1;
      n_chk++; if (dload[0] !== 32'h5678 || ramstore !== 32'h5678 || ramaddr !== 32'h304 || dwait !== 2'b00)
         $display("FAIL c2c_w1 got=%h %h %h %b exp=5678 5678 304 00", dload[0], ramstore, ramaddr, dwait); else n_pass++;
      @(negedge CLK); clear_inputs(); #1;
      n_chk++; if (ccwait !== 2'b00 || ramWEN !== 1'b0 || dwait !== 2'b11)
         $display("FAIL c2c_end got=%b %b %b exp=00 0 11", ccwait, ramWEN, dwait); else n_pass++;
   endtask

   task automatic test_upgrade();
      @(negedge CLK); cctrans = 2'b10; ccwrite = 2'b10; daddr[1] = 32'h400; #1;
      @(negedge CLK); #1;
      n_chk++; if (ccwait !== 2'b01 || ccinv !== 2'b01 || ccsnoopaddr[0] !== 32'h400)
         $display("FAIL upg_snoop got=%b %b %h exp=01 01 400", ccwait, ccinv, ccsnoopaddr[0]); else n_pass++;
      @(negedge CLK); cctrans = 2'b00; ccwrite = 2'b00; #1;
      n_chk++; if (ccwait !== 2'b01 || ramREN !== 1'b0 || ramWEN !== 1'b0)
         $display("FAIL upg_upg got=%b %b%b exp=01 00", ccwait, ramREN, ramWEN); else n_pass++;
      @(negedge CLK); #1;
      n_chk++; if (ccwait !== 2'b00 || ramREN !== 1'b0 || ramWEN !== 1'b0)
         $display("FAIL upg_idle got=%b %b%b exp=00 00", ccwait, ramREN, ramWEN); else n_pass++;
   endtask

   task automatic test_tie_reset();
      logic       g2;
      logic [1:0] exp_cw;
      logic [31:0] exp_dl;
`ifdef CC_ARB_RR_EN
      g2 = 1'b1;
`else
      g2 = 1'b0;
`endif
      exp_cw = g2 ? 2'b01 : 2'b10;
      exp_dl = g2 ? 32'hD0 : 32'hD1;
      @(negedge CLK); cctrans = 2'b11; dREN = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600; #1;
      @(negedge CLK); #1;
      n_chk++; if (ccwait !== 2'b10 || ccsnoopaddr[1] !== 32'h500)
         $display("FAIL tie1_grant got=%b %h exp=10 500", ccwait, ccsnoopaddr[1]); else n_pass++;
      @(negedge CLK); ramstate = ACCESS; ramload = 32'h11; #1;
      n_chk++; if (dload[0] !== 32'h11 || dload[1] !== 32'h0 || dwait !== 2'b10)
         $display("FAIL tie1_rd got=%h %h %b exp=11 0 10", dload[0], dload[1], dwait); else n_pass++;
      @(negedge CLK); ramload = 32'h22; #1;
      @(negedge CLK); ramstate = FREE; ccwrite = 2'b11; #1;
      n_chk++; if (ccwait !== 2'b00 || dwait !== 2'b11) $display("FAIL tie1_end got=%b %b exp=00 11", ccwait, dwait); else n_pass++;
      @(negedge CLK); #1;
      n_chk++; if (ccwait !== exp_cw || ccinv !== exp_cw) $display("FAIL tie2_grant got=%b %b exp=%b", ccwait, ccinv, exp_cw); else n_pass++;
      @(negedge CLK); dstore[0] = 32'hD0; dstore[1] = 32'hD1; ramstate = BUSY; #1;
      n_chk++; if (ramWEN !== 1'b1 || dload[g2] !== exp_dl || dwait !== 2'b11)
         $display("FAIL tie2_c2c got=%b %h %b exp=1 %h 11", ramWEN, dload[g2], dwait, exp_dl); else n_pass++;
      ramstate = ACCESS; nRST = 1'b0; #1;
      n_chk++; if (dwait !== 2'b11 || ccwait !== 2'b00 || ccinv !== 2'b00 || ramREN !== 1'b0 || ramWEN !== 1'b0)
         $display("FAIL arst_ctl got=%b %b %b %b%b exp=11 00 00 00", dwait, ccwait, ccinv, ramREN, ramWEN); else n_pass++;
      n_chk++; if (ramaddr !== 32'h0 || ramstore !== 32'h0 || dload !== 64'h0 || ccsnoopaddr !== 64'h0)
         $display("FAIL arst_data got=%h %h %h %h exp=0", ramaddr, ramstore, dload, ccsnoopaddr); else n_pass++;
      @(negedge CLK); clear_inputs(); cctrans = 2'b11; dREN = 2'b11; nRST = 1'b1; #1;
      @(negedge CLK); #1;
      n_chk++; if (ccwait !== 2'b10) $display("FAIL tie3_ptr_rst got=%b exp=10", ccwait); else n_pass++;
      @(negedge CLK); ramstate = ACCESS; #1;
      @(negedge CLK); #1;
      @(negedge CLK); clear_inputs(); #1;
      n_chk++; if (ccwait !== 2'b00 || ramREN !== 1'b0) $display("FAIL tie3_end got=%b %b exp=00 0", ccwait, ramREN); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_evict();
      test_read_miss();
      test_c2c();
      test_upgrade();
      test_tie_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cc_bus_ctrl.md
Name: cc_bus_ctrl

Overview:
- Dual-core coherence bus controller sitting directly downstream of the two MSI data caches and upstream of the single-ported RAM.
- Arbitrates data-cache requests and snoops the non-requesting cache.
- Services a miss either by cache-to-cache transfer, with concurrent RAM writeback, when the snooped line is Modified, or by a RAM read otherwise.
- Passes plain eviction writebacks straight through to RAM.

Parameters:
- NCORE, 2, number of data caches (fixed at 2; index g = granted core, o = ~g).
- BLKWORDS, 2, words per cache block; sets the transfer count.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- dREN  in  2  per-core data read request
- dWEN  in  2  per-core data write request (eviction or snoop supply)
- daddr  in  2x32  per-core word address
- dstore  in  2x32  per-core write data
- cctrans  in  2  per-core coherence transaction request
- ccwrite  in  2  requester: intent to modify; snooped core: line is M
- dwait  out  2  per-core stall, low for exactly the cycle a word completes
- dload  out  2x32  per-core read data
- ccwait  out  2  snoop in progress on that core
- ccinv  out  2  invalidate snooped line
- ccsnoopaddr  out  2x32  snoop address
- ramREN  out  1  RAM read
- ramWEN  out  1  RAM write
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Clock and reset: CLK, nRST; reset asynchronous, active-low.
- Reset values:
  - dwait=2'b11; ccwait, ccinv, ramREN, ramWEN = 0.
  - ramaddr, ramstore, dload, ccsnoopaddr = 0.
  - State IDLE, word count 0, priority pointer 0.
  - Reset mid-transaction aborts immediately; no completion is signalled.
- Word done: done = (ramstate==ACCESS). ERROR and BUSY are treated as not done and hold the state.
- States: IDLE, WB, SNOOP, C2C, RAMRD, UPG.
- IDLE:
  - A core is requesting if cctrans[i] | dWEN[i].
  - The arbiter picks g and latches it.
  - dWEN[g] & ~cctrans[g] -> WB; otherwise -> SNOOP.
  - No RAM strobes and all dwait high.
- WB:
  - ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g], dwait[g]=~done.
  - Exit to IDLE after BLKWORDS dones, or if dWEN[g] drops.
- SNOOP (exactly 1 cycle):
  - ccwait[o]=1, ccsnoopaddr[o]=daddr[g], ccinv[o]=ccwrite[g].
  - Next state: ccwrite[o] -> C2C; else dREN[g] -> RAMRD; else -> UPG.
- C2C:
  - ccwait[o] held, ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o].
  - dload[g]=dstore[o]; dwait[g]=dwait[o]=~done.
  - After BLKWORDS dones -> IDLE.
- RAMRD:
  - ccwait[o] held, ramREN=1, ramaddr=daddr[g], dload[g]=ramload, dwait[g]=~done.
  - After BLKWORDS dones -> IDLE.
- UPG (S->M upgrade, 1 cycle):
  - ccwait[o] held; cctrans/ccwrite of g observed low next cycle.
  - -> IDLE.
- ccwait[o] deasserts on the cycle the FSM returns to IDLE; the snooper sees a clean falling edge.
- ccinv is valid only while ccwait is high.
- At most one of ramREN/ramWEN is ever high.
- Word counter is 1 bit (log2 BLKWORDS); it wraps to 0 on exit.
- A new grant is possible no earlier than the cycle after IDLE.
- Simultaneous requests in IDLE: one grant per the arbiter; the loser keeps dwait high.
- Requests arriving mid-transaction wait.
- dload for a non-granted core is 0.

Optional Feature:
- Macro: CC_ARB_RR_EN.
- Defined: round-robin arbitration. The pointer flips to o after every completed grant, and it is pointer-first on a tie.
- Undefined: fixed priority, core 0 always wins a tie.

Test Plan:
- Core0 eviction: dWEN[0]=1, daddr=0x100/0x104, dstore=0xAAAA/0xBBBB, RAM ACCESS after 2 BUSY -> two ramWEN writes at 0x100/0x104; dwait[0] low one cycle each; back to IDLE; ccwait=0.
- Core1 read miss, core0 line S/I: cctrans[1]=1, dREN[1]=1, daddr=0x200 -> SNOOP with ccsnoopaddr[0]=0x200, ccinv[0]=0, then RAMRD; dload[1]=ramload for 0x200/0x204.
- Core0 write miss, core1 line M: cctrans[0]=ccwrite[0]=1, core1 answers ccwrite[1]=1, dstore[1]=0x1234/0x5678 -> ccinv[1]=1; C2C delivers dload[0]=0x1234 then 0x5678; RAM written 0x1234 then 0x5678; dwait[0]/dwait[1] low together.
- Upgrade: cctrans[1]=ccwrite[1]=1, dREN[1]=0, core0 line S -> SNOOP, UPG, IDLE in 3 cycles; ccinv[0]=1; no RAM strobe.
- Tie and reset: both cctrans high -> core0 granted; with CC_ARB_RR_EN the next tie grants core1. Assert nRST in C2C -> all outputs at reset values with no clock edge needed.
